// File: rtl/bus_master_if.sv
// ----------------------------------------------------------------------------
// bus_master_if
//
// Purpose: groups the core-side request/response handshake and the peripheral
// bus signals of bus_master into one bundle.
//
// Signals:
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_be : core request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err               : core response channel
//   bus_en/bus_we/bus_addr/bus_wdata/bus_be             : strobe + latched request
//   bus_hit/bus_ack/bus_rdata                           : decoder hit, device completion
//
// Modports:
//   master : the sequencer (bus_master) view
//   slave  : the surrounding world (core + devices) view
// ----------------------------------------------------------------------------
interface bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        bus_en;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_hit;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output bus_en, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_hit, bus_ack, bus_rdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  bus_en, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_hit, bus_ack, bus_rdata
    );
endinterface

// File: rtl/bus_master.sv
// ----------------------------------------------------------------------------
// bus_master
//
// Purpose: single-outstanding request sequencer between the load/store unit
// and the address-decoded peripheral bus. A request is accepted on a
// valid/ready handshake, its fields are latched onto bus_*, the decoders'
// wired-OR busy (bus_hit) is sampled one cycle later, then bus_en is pulsed
// for one cycle and the device acknowledge is awaited with a timeout. The
// result (read data or error) is held on rsp_* until the core accepts it.
//
// Parameters:
//   TIMEOUT : cycles from the bus_en cycle (inclusive) to bus_ack before an
//             error response is returned; 1..255.
//
// Ports:
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bif   : bus_master_if.master (request, response and peripheral bus)
//
// Build option:
//   BUS_MASTER_ALIGN_CHECK_EN : when defined, misaligned word/halfword
//   requests are rejected with rsp_err=1 in DECODE, before the bus_hit check,
//   and never reach the bus.
// ----------------------------------------------------------------------------
module bus_master #(
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          n_rst,
    bus_master_if.master  bif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_reg,     state_next;
    logic        req_ready_reg, req_ready_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_rdata_reg, rsp_rdata_next;
    logic        rsp_err_reg,   rsp_err_next;
    logic        bus_en_reg,    bus_en_next;
    logic        bus_we_reg,    bus_we_next;
    logic [31:0] bus_addr_reg,  bus_addr_next;
    logic [31:0] bus_wdata_reg, bus_wdata_next;
    logic [3:0]  bus_be_reg,    bus_be_next;
    logic [7:0]  cnt_reg,       cnt_next;

    logic        misaligned;
    logic [31:0] ack_rdata;

    // Read data as returned to the core: writes always report zero, so each
    // byte lane is gated by the latched direction.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rdata_lane
            assign ack_rdata[8*gi +: 8] = bus_we_reg ? 8'h00 : bif.bus_rdata[8*gi +: 8];
        end
    endgenerate

`ifdef BUS_MASTER_ALIGN_CHECK_EN
    // Evaluated on the latched request while in DECODE.
    always_comb begin
        misaligned = 1'b0;
        if (bus_be_reg == 4'b1111 && bus_addr_reg[1:0] != 2'b00) begin
            misaligned = 1'b1;
        end else if ((bus_be_reg == 4'b0011 || bus_be_reg == 4'b1100) && bus_addr_reg[0]) begin
            misaligned = 1'b1;
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    // State and all outputs are registered; the combinational process below
    // computes every next value.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
            bus_en_reg    <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= 32'h0;
            bus_wdata_reg <= 32'h0;
            bus_be_reg    <= 4'h0;
            cnt_reg       <= 8'h0;
        end else begin
            state_reg     <= state_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
            bus_en_reg    <= bus_en_next;
            bus_we_reg    <= bus_we_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            bus_be_reg    <= bus_be_next;
            cnt_reg       <= cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        req_ready_next = req_ready_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        bus_en_next    = 1'b0;          // strobe: high for one cycle only
        bus_we_next    = bus_we_reg;    // bus_* hold the last request
        bus_addr_next  = bus_addr_reg;
        bus_wdata_next = bus_wdata_reg;
        bus_be_next    = bus_be_reg;
        cnt_next       = cnt_reg;

        unique case (state_reg)
            ST_IDLE: begin
                // req_ready comes up one edge after reset release, and one
                // edge after a response handshake.
                req_ready_next = 1'b1;
                if (bif.req_valid && req_ready_reg) begin
                    bus_we_next    = bif.req_we;
                    bus_addr_next  = bif.req_addr;
                    bus_wdata_next = bif.req_wdata;
                    bus_be_next    = bif.req_be;
                    req_ready_next = 1'b0;
                    state_next     = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (misaligned || !bif.bus_hit) begin
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = 32'h0;
                    state_next     = ST_RESP;
                end else begin
                    bus_en_next = 1'b1;
                    cnt_next    = 8'd1;     // the enable cycle is counted
                    state_next  = ST_ACCESS;
                end
            end

            ST_ACCESS, ST_WAIT: begin
                // Acknowledge takes priority over the timeout in the same cycle.
                if (bif.bus_ack) begin
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b0;
                    rsp_rdata_next = ack_rdata;
                    state_next     = ST_RESP;
                end else if (cnt_reg == TIMEOUT_CNT) begin
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = 32'h0;
                    state_next     = ST_RESP;
                end else begin
                    cnt_next   = cnt_reg + 8'd1;
                    state_next = ST_WAIT;
                end
            end

            ST_RESP: begin
                if (rsp_valid_reg && bif.rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    req_ready_next = 1'b1;
                    state_next     = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bif.req_ready = req_ready_reg;
    assign bif.rsp_valid = rsp_valid_reg;
    assign bif.rsp_rdata = rsp_rdata_reg;
    assign bif.rsp_err   = rsp_err_reg;
    assign bif.bus_en    = bus_en_reg;
    assign bif.bus_we    = bus_we_reg;
    assign bif.bus_addr  = bus_addr_reg;
    assign bif.bus_wdata = bus_wdata_reg;
    assign bif.bus_be    = bus_be_reg;

endmodule

// File: tb/tb_bus_master.sv
// ----------------------------------------------------------------------------
// tb_bus_master
//
// Purpose: self-checking bench for bus_master with TIMEOUT=4. Expected
// responses are pushed to a scoreboard queue when a request is driven and
// popped at the response handshake. Response latency and bus_en behaviour
// are checked per transaction.
// ----------------------------------------------------------------------------
module tb_bus_master;

    localparam int TO = 4;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;     // edges from accept edge to rsp_valid visible
        int          en_cnt;  // expected number of bus_en cycles
    } exp_t;

    logic clk;
    logic n_rst;

    bus_master_if bif ();

    bus_master #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bif   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_txn = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_misaligned(input logic [31:0] addr, input logic [3:0] be);
`ifdef BUS_MASTER_ALIGN_CHECK_EN
        if (be == 4'b1111) return addr[1:0] != 2'b00;
        if (be == 4'b0011 || be == 4'b1100) return addr[0];
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // ack_k: cycle offset of bus_ack relative to the bus_en cycle (0 = same
    // cycle), negative = device never acknowledges.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic hit, input int ack_k,
                          input logic [31:0] dev_rdata, input int rsp_wait);
        exp_t        e;
        exp_t        p;
        int          t;
        int          en_cnt;
        int          en_t;
        bit          seen;
        logic [31:0] hold_rdata;
        logic        hold_err;

        if (is_misaligned(addr, be) || !hit) begin
            e.err = 1'b1; e.rdata = 32'h0; e.lat = 1; e.en_cnt = 0;
        end else if (ack_k >= 0 && ack_k < TO) begin
            e.err = 1'b0; e.rdata = we ? 32'h0 : dev_rdata; e.lat = 2 + ack_k; e.en_cnt = 1;
        end else begin
            e.err = 1'b1; e.rdata = 32'h0; e.lat = 1 + TO; e.en_cnt = 1;
        end
        sb_q.push_back(e);

        bif.req_valid = 1'b1;
        bif.req_we    = we;
        bif.req_addr  = addr;
        bif.req_wdata = wdata;
        bif.req_be    = be;
        bif.bus_hit   = hit;
        bif.bus_rdata = dev_rdata;
        check("req_ready_idle", 32'(bif.req_ready), 32'd1);
        tick();                                   // accept edge N
        bif.req_valid = 1'b0;
        bif.req_addr  = $urandom;                 // bus_* must stay latched
        bif.req_wdata = $urandom;
        bif.req_we    = ~we;
        check("req_ready_busy", 32'(bif.req_ready), 32'd0);
        check("bus_addr", bif.bus_addr, addr);
        check("bus_wdata", bif.bus_wdata, wdata);
        check("bus_we_be", {27'd0, bif.bus_we, bif.bus_be}, {27'd0, we, be});

        t = 0; en_cnt = 0; en_t = -1; seen = 1'b0;
        while (!seen && t < 300) begin
            tick();
            t++;
            bif.bus_ack = (ack_k >= 0 && t == 1 + ack_k);
            if (bif.bus_en) begin
                en_cnt++;
                en_t = t;
            end
            if (bif.rsp_valid) seen = 1'b1;
        end
        bif.bus_ack = 1'b0;
        bif.bus_hit = 1'b0;
        check("rsp_latency", 32'(t), 32'(e.lat));
        check("bus_en_count", 32'(en_cnt), 32'(e.en_cnt));
        if (e.en_cnt == 1) check("bus_en_cycle", 32'(en_t), 32'd1);

        // Hold the response off; stray acks with new data must be ignored.
        hold_rdata = bif.rsp_rdata;
        hold_err   = bif.rsp_err;
        for (int i = 0; i < rsp_wait; i++) begin
            bif.bus_ack   = 1'b1;
            bif.bus_rdata = 32'hBAD0_0000 | 32'(i);
            tick();
            check("rsp_hold_valid", 32'(bif.rsp_valid), 32'd1);
            check("rsp_hold_data", {bif.rsp_err, bif.rsp_rdata[30:0]}, {hold_err, hold_rdata[30:0]});
        end
        bif.bus_ack   = 1'b0;
        bif.rsp_ready = 1'b1;

        p = sb_q.pop_front();
        check("rsp_err", 32'(bif.rsp_err), 32'(p.err));
        check("rsp_rdata", bif.rsp_rdata, p.rdata);
        $display("txn %0d: we=%0d addr=0x%08h be=%b hit=%0d ack_k=%0d -> err=%0d rdata=0x%08h lat=%0d",
                 n_txn, we, addr, be, hit, ack_k, bif.rsp_err, bif.rsp_rdata, t);
        n_txn++;
        tick();                                   // response handshake edge
        bif.rsp_ready = 1'b0;
        check("rsp_valid_after", 32'(bif.rsp_valid), 32'd0);
        check("req_ready_after", 32'(bif.req_ready), 32'd1);
    endtask

    initial begin
        bit stray;

        n_rst         = 1'b0;
        bif.req_valid = 1'b0;
        bif.req_we    = 1'b0;
        bif.req_addr  = 32'h0;
        bif.req_wdata = 32'h0;
        bif.req_be    = 4'h0;
        bif.rsp_ready = 1'b0;
        bif.bus_hit   = 1'b0;
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 32'h0;

        // Reset state and release
        repeat (3) tick();
        check("rst_req_ready", 32'(bif.req_ready), 32'd0);
        check("rst_rsp", {30'd0, bif.rsp_valid, bif.rsp_err}, 32'd0);
        check("rst_rsp_rdata", bif.rsp_rdata, 32'd0);
        check("rst_bus_addr", bif.bus_addr, 32'd0);
        check("rst_bus_wdata", bif.bus_wdata, 32'd0);
        check("rst_bus_ctl", {26'd0, bif.bus_en, bif.bus_we, bif.bus_be}, 32'd0);
        n_rst = 1'b1;
        #1;
        check("req_ready_before_edge", 32'(bif.req_ready), 32'd0);
        tick();
        check("req_ready_after_rel", 32'(bif.req_ready), 32'd1);

        //      we    addr          wdata         be       hit   ack_k dev_rdata     wait
        do_txn(1'b0, 32'h0000_0010, 32'h0,        4'b1111, 1'b1,  0, 32'hDEAD_BEEF, 0);
        do_txn(1'b0, 32'h4000_0000, 32'h0,        4'b1111, 1'b0, -1, 32'h1111_2222, 0);
        do_txn(1'b0, 32'h0000_0100, 32'h0,        4'b1111, 1'b1, -1, 32'h3333_4444, 1);
        do_txn(1'b0, 32'h0000_0104, 32'h0,        4'b1111, 1'b1,  3, 32'hCAFE_F00D, 0);
        do_txn(1'b1, 32'h0000_0004, 32'h1234_5678, 4'b1111, 1'b1, 2, 32'hFFFF_FFFF, 3);
        do_txn(1'b0, 32'h0000_0108, 32'h0,        4'b1111, 1'b1,  4, 32'h5555_6666, 0);
        do_txn(1'b1, 32'h0000_0002, 32'hA5A5_5A5A, 4'b1111, 1'b1, 1, 32'h0,        0);
        do_txn(1'b0, 32'h0000_0021, 32'h0,        4'b0011, 1'b1,  0, 32'h0BAD_F00D, 2);
        do_txn(1'b0, 32'h0000_0022, 32'h0,        4'b1100, 1'b1,  1, 32'h7777_8888, 0);

        // Reset pulsed while waiting for an acknowledge
        bif.req_valid = 1'b1;
        bif.req_we    = 1'b0;
        bif.req_addr  = 32'h0000_0200;
        bif.req_be    = 4'b1111;
        bif.bus_hit   = 1'b1;
        tick();
        bif.req_valid = 1'b0;
        repeat (3) tick();                        // DECODE, ACCESS, WAIT
        #2;
        n_rst = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        check("midrst_bus_en", 32'(bif.bus_en), 32'd0);
        check("midrst_req_ready", 32'(bif.req_ready), 32'd0);
        check("midrst_bus_addr", bif.bus_addr, 32'd0);
        bif.bus_hit = 1'b0;
        bif.bus_ack = 1'b1;                       // late ack must not revive the request
        tick();
        n_rst = 1'b1;
        tick();
        bif.bus_ack = 1'b0;
        check("midrst_ready_back", 32'(bif.req_ready), 32'd1);
        stray = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bif.rsp_valid || bif.bus_en) stray = 1'b1;
        end
        check("midrst_no_rsp", 32'(stray), 32'd0);

        // Recovery after reset
        do_txn(1'b0, 32'h0000_0300, 32'h0, 4'b1111, 1'b1, 0, 32'h0123_4567, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_master.md
Name: bus_master

Overview:
- Single-outstanding bus request sequencer between the core's load/store unit and the address-decoded peripheral bus.
- Accepts one request per valid/ready handshake, presents the address so the per-device decoders can report a hit, then pulses the bus enable.
- Waits for device acknowledge with a timeout, and returns read data or an error to the core.
- The wired-OR of every decoder's busy output feeds bus_hit.

Parameters:
TIMEOUT, 16, max cycles from enable pulse (inclusive) to bus_ack before error; legal range 1..255

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
req_valid  input  1  core request valid
req_ready  output  1  block can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  32  byte address
req_wdata  input  32  write data
req_be  input  4  byte enables
rsp_valid  output  1  response valid, held until rsp_ready
rsp_ready  input  1  core accepts response
rsp_rdata  output  32  read data (0 for writes and errors)
rsp_err  output  1  1 = unmapped, timeout (or misaligned, see option)
bus_en  output  1  one-cycle access strobe to device decoders
bus_we  output  1  latched req_we
bus_addr  output  32  latched req_addr
bus_wdata  output  32  latched req_wdata
bus_be  output  4  latched req_be
bus_hit  input  1  OR of all decoder busy flags for bus_addr
bus_ack  input  1  device completion, one cycle
bus_rdata  input  32  device read data, valid with bus_ack

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous, active-low.
- Reset values: state IDLE; req_ready=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; bus_en=0; bus_we=0; bus_addr=0; bus_wdata=0; bus_be=0; timeout counter=0.
  - req_ready is a flop; it goes to 1 on the first rising edge after n_rst deasserts.
- Reset asserted mid-operation: all outputs return to reset values immediately; any in-flight request is dropped without a response.
- State IDLE:
  - req_ready=1.
  - On req_valid & req_ready at edge N: latch we/addr/wdata/be onto the bus_* outputs; req_ready=0; go to DECODE.
- State DECODE (cycle N+1):
  - bus_en=0; bus_hit is sampled.
  - bus_hit=0: go to RESP with rsp_err=1, rdata=0. bus_en is never asserted for this request.
  - bus_hit=1: go to ACCESS.
- State ACCESS (cycle N+2):
  - bus_en=1 for exactly this cycle; counter loads 1.
  - If bus_ack is high in this cycle: capture bus_rdata (reads only) and go to RESP, so rsp_valid=1 at N+3.
  - Otherwise go to WAIT.
- State WAIT:
  - bus_en=0; counter increments each cycle.
  - On bus_ack: capture data, err=0, go to RESP.
  - If counter==TIMEOUT and no bus_ack: err=1, rdata=0, go to RESP.
  - bus_ack together with the timeout cycle: ack wins.
  - TIMEOUT=1: if no ack in ACCESS, timeout is raised leaving ACCESS.
- State RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid=0, req_ready=1, go to IDLE.
  - Next request accepted no earlier than one cycle after the response handshake.
- bus_ack outside ACCESS/WAIT is ignored.
- bus_* data outputs hold the last request's values while IDLE.
- Counter width is 8 bits; it never wraps (TIMEOUT≤255).
- Writes: rsp_rdata=0 regardless of bus_rdata.

Optional Feature:
- Macro BUS_MASTER_ALIGN_CHECK_EN.
- Defined: in DECODE, a misaligned request produces RESP with rsp_err=1 before the bus_hit check, and bus_en is never asserted. A request is misaligned when either:
  - req_be is 4'b1111 and addr[1:0]!=0, or
  - req_be is 4'b0011/4'b1100 and addr[0]!=0.
- Undefined: no alignment check; the address is passed unchanged and only unmapped/timeout errors exist.

Test Plan:
- Reset release: req_ready=0 during reset, 1 one edge after n_rst rises; all bus_* outputs 0.
- Read 0x00000010, bus_hit=1, bus_ack with rdata 0xDEADBEEF in the ACCESS cycle -> bus_en high exactly at N+2; rsp_valid at N+3, rdata=0xDEADBEEF, err=0.
- Read 0x40000000, bus_hit=0 -> rsp_valid at N+2, err=1, rdata=0, bus_en never 1.
- TIMEOUT=4, bus_hit=1, no ack -> rsp_valid at N+6, err=1. Repeat with ack on the 4th counted cycle -> err=0, data returned.
- Write 0x00000004, wdata 0x12345678, ack after 2 wait cycles, rsp_ready held low 3 cycles -> rsp_valid stays high with rdata=0, err=0 until rsp_ready; req_ready returns 1 the next cycle.
- n_rst pulsed low during WAIT -> bus_en/rsp_valid 0 immediately, no response issued. With BUS_MASTER_ALIGN_CHECK_EN, a full-word write to 0x00000002 -> err=1 at N+2, no bus_en.
